// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : stream_checker
// Purpose  : Avalon-ST sink that checks an incrementing data sequence,
//            counts beats / mismatches / errored beats, and exposes the
//            results through a small Avalon-MM CSR block with an interrupt.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                  in   clock, rising edge
//   reset                in   asynchronous active-high reset
//   avalonst_sink_valid  in   upstream beat valid
//   avalonst_sink_data   in   beat payload (DATA_W)
//   avalonst_sink_error  in   beat error flags (ERR_W)
//   avalonst_sink_ready  out  sink ready (register-derived only)
//   avs_address          in   CSR word address (3 bits)
//   avs_read             in   CSR read strobe
//   avs_readdata         out  CSR read data, one cycle after avs_read
//   avs_write            in   CSR write strobe
//   avs_writedata        in   CSR write data
//   irq                  out  level interrupt, active-high
// ============================================================================
module stream_checker #(
  parameter int DATA_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avalonst_sink_valid,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  input  logic [ERR_W-1:0]  avalonst_sink_error,
  output logic              avalonst_sink_ready,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] C_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [7:0]        bp_q, bp_d;
  logic [2:0]        phase_q, phase_d;
  logic [DATA_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [DATA_W-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              mis_sticky_q, mis_sticky_d;
  logic              err_sticky_q, err_sticky_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              w_ctrl_wr, w_clear, w_stat_wr, w_bp_wr;
  logic              w_beat, w_err_beat, w_mis;
  logic [DATA_W-1:0] w_rd_mux;

  // Only bits [7:0] of the write data are ever used by the CSR map.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[DATA_W-1:8];

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + C_ONE;
  endfunction

  // Ready depends on registers only, so reset drops it asynchronously.
  assign avalonst_sink_ready = enable_q & bp_q[phase_q];
  assign avs_readdata        = readdata_q;
  assign irq                 = irq_q;

  assign w_ctrl_wr  = avs_write && (avs_address == 3'd0);
  assign w_clear    = w_ctrl_wr && avs_writedata[1];
  assign w_stat_wr  = avs_write && (avs_address == 3'd1);
  assign w_bp_wr    = avs_write && (avs_address == 3'd7);
  // A beat coinciding with a clear is dropped entirely.
  assign w_beat     = avalonst_sink_valid && avalonst_sink_ready && !w_clear;
  assign w_err_beat = w_beat && (avalonst_sink_error != '0);
  assign w_mis      = w_beat && (state_q == ST_CHECK) &&
                      (avalonst_sink_data != expected_q);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_clear)
      state_d = avs_writedata[0] ? ST_SYNC : ST_IDLE;
    else if (w_ctrl_wr && !avs_writedata[0])
      state_d = ST_IDLE;
    else if (w_ctrl_wr && (state_q == ST_IDLE))
      state_d = ST_SYNC;
    else if ((state_q == ST_SYNC) && w_beat)
      state_d = ST_CHECK;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    bp_d         = bp_q;
    phase_d      = enable_q ? phase_q + 3'd1 : 3'd0;
    beat_cnt_d   = beat_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    err_cnt_d    = err_cnt_q;
    last_d       = last_q;
    expected_d   = expected_q;

    if (w_ctrl_wr) begin
      enable_d = avs_writedata[0];
      irq_en_d = avs_writedata[2];
    end
    if (w_bp_wr) bp_d = avs_writedata[7:0];

    if (w_beat) begin
      beat_cnt_d = sat_inc(beat_cnt_q);
      last_d     = avalonst_sink_data;
      if (w_err_beat) err_cnt_d = sat_inc(err_cnt_q);
      if (w_mis)      mis_cnt_d = sat_inc(mis_cnt_q);
      // SYNC and CHECK both resync to the received value.
      if (state_q != ST_IDLE) expected_d = avalonst_sink_data + C_ONE;
    end

    // A new set event beats a simultaneous write-1-to-clear.
    mis_sticky_d = (mis_sticky_q & ~(w_stat_wr & avs_writedata[0])) | w_mis;
    err_sticky_d = (err_sticky_q & ~(w_stat_wr & avs_writedata[1])) | w_err_beat;

    if (w_clear) begin
      beat_cnt_d   = '0;
      mis_cnt_d    = '0;
      err_cnt_d    = '0;
      last_d       = '0;
      expected_d   = '0;
      mis_sticky_d = 1'b0;
      err_sticky_d = 1'b0;
    end

    irq_d = irq_en_d & (mis_sticky_d | err_sticky_d);
  end

  // CSR read mux, sampled into the readdata register on avs_read.
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      3'd0: begin
        w_rd_mux[0] = enable_q;
        w_rd_mux[2] = irq_en_q;
      end
      3'd1: begin
        w_rd_mux[0]   = mis_sticky_q;
        w_rd_mux[1]   = err_sticky_q;
        w_rd_mux[3:2] = state_q;
      end
      3'd2:    w_rd_mux = beat_cnt_q;
      3'd3:    w_rd_mux = mis_cnt_q;
      3'd4:    w_rd_mux = err_cnt_q;
      3'd5:    w_rd_mux = last_q;
      3'd6:    w_rd_mux = expected_q;
      default: w_rd_mux[7:0] = bp_q;
    endcase
    readdata_d = avs_read ? w_rd_mux : readdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      bp_q         <= 8'hFF;
      phase_q      <= 3'd0;
      beat_cnt_q   <= '0;
      mis_cnt_q    <= '0;
      err_cnt_q    <= '0;
      last_q       <= '0;
      expected_q   <= '0;
      mis_sticky_q <= 1'b0;
      err_sticky_q <= 1'b0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      bp_q         <= bp_d;
      phase_q      <= phase_d;
      beat_cnt_q   <= beat_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      err_cnt_q    <= err_cnt_d;
      last_q       <= last_d;
      expected_q   <= expected_d;
      mis_sticky_q <= mis_sticky_d;
      err_sticky_q <= err_sticky_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter DATA_W, 32, sink data width and CSR data width.
REQ-002 Parameter ERR_W, 8, sink error width.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 avalonst_sink_valid  input  1  upstream beat valid.
REQ-006 avalonst_sink_data  input  DATA_W  beat payload (incrementing sequence expected).
REQ-007 avalonst_sink_error  input  ERR_W  beat error flags.
REQ-008 avalonst_sink_ready  output  1  sink ready to accept.
REQ-009 avs_address  input  3  CSR word address.
REQ-010 avs_read  input  1  CSR read strobe.
REQ-011 avs_readdata  output  DATA_W  CSR read data.
REQ-012 avs_write  input  1  CSR write strobe.
REQ-013 avs_writedata  input  DATA_W  CSR write data.
REQ-014 irq  output  1  interrupt, level, active-high.

Function
REQ-015 Beat accepted SHALL be exactly the cycles where valid=1 and ready=1 at a rising edge; valid without ready SHALL have no effect.
REQ-016 ready SHALL be driven from registers only, no combinational path from any input: ready = CTRL.enable & BP[phase], where phase is a 3-bit counter that advances every cycle while enable=1 and holds at 0 while enable=0.
REQ-017 The state machine SHALL have 3 states: IDLE=0, SYNC=1, CHECK=2.
  - IDLE: enable=0.
  - IDLE->SYNC on enable set.
  - SYNC->CHECK on the first accepted beat.
  - Any state->IDLE on enable clear.
REQ-018 In SYNC, the accepted beat SHALL load EXPECTED=data+1 with no compare.
REQ-019 In CHECK, each accepted beat SHALL be compared with EXPECTED.
  - On mismatch: MISMATCH_CNT++ and STATUS.mismatch set.
  - Either way: EXPECTED := data+1 (resync).
REQ-020 EXPECTED arithmetic SHALL be modulo 2^DATA_W; 0xFFFFFFFF followed by 0x00000000 SHALL NOT be a mismatch.
REQ-021 Every accepted beat SHALL do BEAT_CNT++ and LAST_DATA := data.
  - Also, if error!=0: ERRBEAT_CNT++ and STATUS.error set.
REQ-022 All counters SHALL saturate at 0xFFFFFFFF, not wrap.
REQ-023 CSR map (word addresses):
  - 0 CTRL rw: bit0 enable, bit1 clear (write-only, self-clearing, reads 0), bit2 irq_en.
  - 1 STATUS: bit0 mismatch, bit1 error (sticky, write-1-to-clear), bits3:2 state (ro).
  - 2 BEAT_CNT ro.
  - 3 MISMATCH_CNT ro.
  - 4 ERRBEAT_CNT ro.
  - 5 LAST_DATA ro.
  - 6 EXPECTED ro.
  - 7 BP rw, bits7:0 ready pattern.
  - Unused bits read 0.
REQ-024 avs_readdata SHALL be registered, valid one cycle after avs_read; it SHALL hold its value when avs_read=0.
REQ-025 A CTRL write with clear=1 SHALL:
  - zero all counters, STATUS stickies, LAST_DATA and EXPECTED;
  - force state to SYNC if the written enable=1, otherwise IDLE.
REQ-026 A beat accepted in the same cycle as clear SHALL be discarded entirely (clear wins).
REQ-027 A W1C on STATUS in the same cycle as a new set event for the same bit SHALL leave the bit set.
REQ-028 irq SHALL be registered: irq = irq_en & (mismatch | error), one cycle after the cause.
REQ-029 Writes to read-only addresses SHALL be ignored.

Reset
REQ-030 On reset: ready=0, avs_readdata=0, irq=0, CTRL=0, BP=0xFF, phase=0, state=IDLE; all counters, stickies, LAST_DATA and EXPECTED =0.
REQ-031 Reset asserted mid-stream SHALL take effect immediately (ready=0 asynchronously); the beat on that edge SHALL NOT be counted.

Verification
REQ-032 Enable (CTRL=1), BP=0xFF, source sends 0..99 with continuous valid -> BEAT_CNT=100, MISMATCH_CNT=0, LAST_DATA=99, EXPECTED=100, STATUS=0x8.
REQ-033 Sequence 5,6,8,9 in CHECK -> MISMATCH_CNT=1, STATUS.mismatch=1; with irq_en=1, irq=1 one cycle after the beat carrying 8; W1C 0x1 -> irq=0.
REQ-034 Start at 0xFFFFFFFE, send 3 beats -> MISMATCH_CNT=0, EXPECTED=1.
REQ-035 BP=0x55, valid held high for 16 cycles -> ready toggles 1,0,1,0...; BEAT_CNT=8.
REQ-036 Beat with error=0x04 -> ERRBEAT_CNT=1, STATUS.error=1; CTRL write 0x3 in the same cycle as a beat -> all counters 0, state=SYNC, next beat not compared.
REQ-037 Reset pulse mid-stream -> all outputs at REQ-030 values; CSR read returns 0 for every counter.
